// File: rtl/prog_tick_timer_if.sv
// prog_tick_timer_if: control/status bundle between the tick timer and its user.
interface prog_tick_timer_if #(
   parameter int WIDTH = 21
);
   logic             isEnabled;
   logic             load;
   logic [WIDTH-1:0] periodIn;
   logic             start;
   logic             oneShot;
   logic             tick;
   logic             running;
   logic             done;
   logic [WIDTH-1:0] count;
   modport master (
      output isEnabled, load, periodIn, start, oneShot,
      input  tick, running, done, count
   );
   modport slave (
      input  isEnabled, load, periodIn, start, oneShot,
      output tick, running, done, count
   );
endinterface

// File: rtl/prog_tick_timer.sv
// prog_tick_timer: programmable periodic/one-shot tick generator with pause and re-arm.
module prog_tick_timer #(
   parameter int WIDTH          = 21,
   parameter int DEFAULT_PERIOD = 2000000,
   parameter bit AUTO_START     = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   prog_tick_timer_if.slave bus
);
   logic [WIDTH-1:0] count_q, count_d, period_q, period_d, term;
   logic             tick_q, tick_d, running_q, running_d, done_q, done_d;
   // a programmed period of 0 behaves as 1, so the terminal value is 0
   assign term = (period_q == '0) ? '0 : period_q - WIDTH'(1);
   always_comb begin
      count_d   = count_q;
      period_d  = period_q;
      tick_d    = 1'b0;
      running_d = running_q;
      done_d    = done_q;
      if (bus.load || bus.start) begin
         count_d   = '0;
         done_d    = 1'b0;
         period_d  = bus.load ? bus.periodIn : period_q;
         running_d = bus.start ? 1'b1 : running_q;
      end else if (running_q && bus.isEnabled) begin
         count_d = (count_q == term) ? '0 : count_q + WIDTH'(1);
         tick_d  = (count_q == term);
         if (count_q == term && bus.oneShot) begin
            running_d = 1'b0;
            done_d    = 1'b1;
         end
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q   <= '0;
         period_q  <= WIDTH'(DEFAULT_PERIOD);
         tick_q    <= 1'b0;
         running_q <= AUTO_START;
         done_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         period_q  <= period_d;
         tick_q    <= tick_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end
   assign bus.count   = count_q;
   assign bus.tick    = tick_q;
   assign bus.running = running_q;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_prog_tick_timer.sv
// tb_prog_tick_timer: directed checks of the tick timer with WIDTH=4, period 5, auto-start.
module tb_prog_tick_timer;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   prog_tick_timer_if #(.WIDTH(4)) bus ();
   prog_tick_timer #(.WIDTH(4), .DEFAULT_PERIOD(5), .AUTO_START(1'b1)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );
   always #5 clock = ~clock;
   task automatic step(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask
   task automatic chk(input string tag, input logic [3:0] c, input logic t, input logic r, input logic d);
      logic [6:0] obs, exp;
      obs = {bus.count, bus.tick, bus.running, bus.done};
      exp = {c, t, r, d};
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed count=%0d tick=%b run=%b done=%b expected count=%0d tick=%b run=%b done=%b",
                tag, obs[6:3], obs[2], obs[1], obs[0], c, t, r, d);
      end
   endtask
   initial begin
      bus.isEnabled = 1'b1;
      bus.load      = 1'b0;
      bus.periodIn  = '0;
      bus.start     = 1'b0;
      bus.oneShot   = 1'b0;
      step(2);
      chk("reset", 4'd0, 1'b0, 1'b1, 1'b0);
      reset = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         step();
         chk("periodic", 4'(i % 5), (i % 5) == 0, 1'b1, 1'b0);
      end
      step(2);
      chk("pre_pause", 4'd2, 1'b0, 1'b1, 1'b0);
      bus.isEnabled = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("paused", 4'd2, 1'b0, 1'b1, 1'b0);
      end
      bus.isEnabled = 1'b1;
      step();
      chk("resume3", 4'd3, 1'b0, 1'b1, 1'b0);
      step();
      chk("resume4", 4'd4, 1'b0, 1'b1, 1'b0);
      step();
      chk("resume_tick", 4'd0, 1'b1, 1'b1, 1'b0);
      bus.oneShot = 1'b1;
      for (int k = 0; k < 2; k++) begin
         bus.start = 1'b1;
         step();
         bus.start = 1'b0;
         chk("os_start", 4'd0, 1'b0, 1'b1, 1'b0);
         for (int i = 1; i <= 4; i++) begin
            step();
            chk("os_count", 4'(i), 1'b0, 1'b1, 1'b0);
         end
         step();
         chk("os_tick", 4'd0, 1'b1, 1'b0, 1'b1);
         for (int i = 0; i < 20; i++) begin
            step();
            chk("os_idle", 4'd0, 1'b0, 1'b0, 1'b1);
         end
      end
      bus.oneShot = 1'b0;
      bus.start   = 1'b1;
      step();
      bus.start = 1'b0;
      step(4);
      chk("pre_load", 4'd4, 1'b0, 1'b1, 1'b0);
      bus.load     = 1'b1;
      bus.periodIn = 4'd2;
      step();
      bus.load = 1'b0;
      chk("load2", 4'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("p2", 4'(i % 2), (i % 2) == 0, 1'b1, 1'b0);
      end
      for (int p = 0; p < 2; p++) begin
         bus.load     = 1'b1;
         bus.periodIn = 4'(p);
         step();
         bus.load = 1'b0;
         chk("load_p01", 4'd0, 1'b0, 1'b1, 1'b0);
         for (int i = 0; i < 4; i++) begin
            step();
            chk("p01_tick", 4'd0, 1'b1, 1'b1, 1'b0);
         end
      end
      bus.load     = 1'b1;
      bus.periodIn = 4'd9;
      step();
      bus.load = 1'b0;
      step(3);
      chk("p9_count3", 4'd3, 1'b0, 1'b1, 1'b0);
      reset        = 1'b1;
      bus.load     = 1'b1;
      bus.start    = 1'b1;
      bus.periodIn = 4'd2;
      step();
      chk("reset_wins", 4'd0, 1'b0, 1'b1, 1'b0);
      reset     = 1'b0;
      bus.load  = 1'b0;
      bus.start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("post_reset_p5", 4'(i % 5), i == 5, 1'b1, 1'b0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
